execute_cycle: RTL and testbench

EXECUTE_CYCLE -- requirements
Module: execute_cycle

---
 rtl/execute_cycle_pkg.sv | 18 +
 rtl/execute_cycle_alu.sv | 34 +++
 rtl/execute_cycle.sv | 138 +++++++++++++
 tb/tb_execute_cycle.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/execute_cycle_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and operand-forwarding selects.
package execute_cycle_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage: add/sub/and/or/signed set-less-than, plus zero flag.
module alu
   import execute_cycle_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [2:0]      ALUControl,
   output logic [XLEN-1:0] Result,
   output logic            Zero
);

   logic signed [XLEN-1:0] src_a_s;
   logic signed [XLEN-1:0] src_b_s;

   assign src_a_s = SrcA;
   assign src_b_s = SrcB;

   always_comb begin
      Result = '0;
      case (ALUControl)
         ALU_ADD: Result = SrcA + SrcB;
         ALU_SUB: Result = SrcA - SrcB;
         ALU_AND: Result = SrcA & SrcB;
         ALU_OR:  Result = SrcA | SrcB;
         ALU_SLT: Result = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
         default: Result = '0;
      endcase
   end

   assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage with E/M pipeline register; operand forwarding enabled by EXECUTE_FORWARDING_EN.
module execute_cycle
   import execute_cycle_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteE,
   input  logic            ALUSrcE,
   input  logic            MemWriteE,
   input  logic            ResultSrcE,
   input  logic            BranchE,
   input  logic [2:0]      ALUControlE,
   input  logic [XLEN-1:0] RD1_E,
   input  logic [XLEN-1:0] RD2_E,
   input  logic [XLEN-1:0] Imm_Ext_E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [REGW-1:0] RD_E,
   input  logic            ValidE,
   input  logic [1:0]      ForwardA_E,
   input  logic [1:0]      ForwardB_E,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic            ResultSrcM,
   output logic            ValidM,
   output logic [REGW-1:0] RD_M,
   output logic [XLEN-1:0] ALU_ResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M
);

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_result;
   logic            zero;

   logic            reg_write_d, reg_write_q;
   logic            mem_write_d, mem_write_q;
   logic            result_src_d, result_src_q;
   logic            valid_d, valid_q;
   logic [REGW-1:0] rd_d, rd_q;
   logic [XLEN-1:0] alu_result_d, alu_result_q;
   logic [XLEN-1:0] write_data_d, write_data_q;
   logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;

`ifdef EXECUTE_FORWARDING_EN
   // The MEM-stage forward source is this block's own registered ALU result.
   always_comb begin
      src_a = RD1_E;
      case (ForwardA_E)
         FWD_WB:  src_a = ResultW;
         FWD_MEM: src_a = alu_result_q;
         default: src_a = RD1_E;
      endcase
   end

   always_comb begin
      fwd_b = RD2_E;
      case (ForwardB_E)
         FWD_WB:  fwd_b = ResultW;
         FWD_MEM: fwd_b = alu_result_q;
         default: fwd_b = RD2_E;
      endcase
   end
`else
   logic unused_fwd;

   assign unused_fwd = ^{ForwardA_E, ForwardB_E, ResultW};
   assign src_a      = RD1_E;
   assign fwd_b      = RD2_E;
`endif

   assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

   alu #(
      .XLEN(XLEN)
   ) u_alu (
      .SrcA      (src_a),
      .SrcB      (src_b),
      .ALUControl(ALUControlE),
      .Result    (alu_result),
      .Zero      (zero)
   );

   assign PCTargetE = PCE + Imm_Ext_E;
   assign PCSrcE    = BranchE & zero & ValidE;

   always_comb begin
      reg_write_d  = RegWriteE & ValidE;
      mem_write_d  = MemWriteE & ValidE;
      result_src_d = ResultSrcE;
      valid_d      = ValidE;
      rd_d         = RD_E;
      alu_result_d = alu_result;
      write_data_d = fwd_b;
      pc_plus4_d   = PCPlus4E;
   end

   // E/M boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         valid_q      <= 1'b0;
         rd_q         <= '0;
         alu_result_q <= '0;
         write_data_q <= '0;
         pc_plus4_q   <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         result_src_q <= result_src_d;
         valid_q      <= valid_d;
         rd_q         <= rd_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         pc_plus4_q   <= pc_plus4_d;
      end
   end

   assign RegWriteM   = reg_write_q;
   assign MemWriteM   = mem_write_q;
   assign ResultSrcM  = result_src_q;
   assign ValidM      = valid_q;
   assign RD_M        = rd_q;
   assign ALU_ResultM = alu_result_q;
   assign WriteDataM  = write_data_q;
   assign PCPlus4M    = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized bench for execute_cycle against a behavioural model of the execute stage.
module tb_execute_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM, ValidM;
   logic [4:0]  RD_M;
   logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;

   int total = 0;
   int bad   = 0;

   // model state: expected M-stage contents
   logic        m_rw, m_mw, m_rs, m_v;
   logic [4:0]  m_rd;
   logic [31:0] m_alu, m_wd, m_pc4;

   execute_cycle dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
      .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ValidE(ValidE),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .ValidM(ValidM), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
      .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] rf);
`ifdef EXECUTE_FORWARDING_EN
      if (sel == 2'd1) return ResultW;
      if (sel == 2'd2) return m_alu;
      return rf;
`else
      return rf;
`endif
   endfunction

   task automatic set_idle();
      rst = 1'b0;
      {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE} = '0;
      ALUControlE = 3'd0;
      RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
      RD_E = 0; ForwardA_E = 0; ForwardB_E = 0;
   endtask

   // Inputs are already driven; check branch outputs, clock once, check M outputs.
   task automatic run_cycle();
      logic [31:0] a, bf, b, res;
      a   = model_fwd(ForwardA_E, RD1_E);
      bf  = model_fwd(ForwardB_E, RD2_E);
      b   = ALUSrcE ? Imm_Ext_E : bf;
      res = model_alu(ALUControlE, a, b);
      #1;
      check_val("pcsrc", {31'd0, PCSrcE}, {31'd0, BranchE && ValidE && (res == 0)});
      check_val("pctarget", PCTargetE, PCE + Imm_Ext_E);
      @(posedge clk);
      if (rst) begin
         {m_rw, m_mw, m_rs, m_v} = '0;
         m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
      end else begin
         m_rw = RegWriteE && ValidE;
         m_mw = MemWriteE && ValidE;
         m_rs = ResultSrcE;
         m_v  = ValidE;
         m_rd = RD_E;
         m_alu = res;
         m_wd = bf;
         m_pc4 = PCPlus4E;
      end
      #1;
      check_val("regwrite_m", {31'd0, RegWriteM}, {31'd0, m_rw});
      check_val("memwrite_m", {31'd0, MemWriteM}, {31'd0, m_mw});
      check_val("resultsrc_m", {31'd0, ResultSrcM}, {31'd0, m_rs});
      check_val("valid_m", {31'd0, ValidM}, {31'd0, m_v});
      check_val("rd_m", {27'd0, RD_M}, {27'd0, m_rd});
      check_val("alu_m", ALU_ResultM, m_alu);
      check_val("wdata_m", WriteDataM, m_wd);
      check_val("pc4_m", PCPlus4M, m_pc4);
   endtask

   initial begin
      {m_rw, m_mw, m_rs, m_v} = '0;
      m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
      set_idle();
      @(posedge clk); #1;

      // reset with live inputs: outputs must clear
      rst = 1'b1; ValidE = 1; RegWriteE = 1; MemWriteE = 1; RD1_E = 32'h1234; RD_E = 5'd9;
      PCPlus4E = 32'h44;
      run_cycle();
      run_cycle();
      check_val("reset_alu", ALU_ResultM, 32'd0);
      check_val("reset_valid", {31'd0, ValidM}, 32'd0);

      // lw x5,4(x0)
      set_idle();
      ALUSrcE = 1; Imm_Ext_E = 4; RD_E = 5; RegWriteE = 1; ResultSrcE = 1; ValidE = 1;
      run_cycle();
      check_val("lw_alu", ALU_ResultM, 32'd4);
      check_val("lw_rd", {27'd0, RD_M}, 32'd5);
      check_val("lw_regwrite", {31'd0, RegWriteM}, 32'd1);
      check_val("lw_resultsrc", {31'd0, ResultSrcM}, 32'd1);

      // beq taken and not taken
      set_idle();
      BranchE = 1; ALUControlE = 3'b001; RD1_E = 7; RD2_E = 7; PCE = 32'h10; Imm_Ext_E = 32'h8;
      ValidE = 1;
      #1;
      check_val("beq_taken", {31'd0, PCSrcE}, 32'd1);
      check_val("beq_target", PCTargetE, 32'h18);
      run_cycle();
      RD2_E = 6;
      #1;
      check_val("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
      run_cycle();

      // forwarding: seed ALU_ResultM with 0x20, then consume it
      set_idle();
      ALUSrcE = 1; RD1_E = 32'h20; ValidE = 1;
      run_cycle();
      ForwardA_E = 2'b10; RD1_E = 32'h99; Imm_Ext_E = 1; ALUSrcE = 1;
      ForwardB_E = 2'b01; ResultW = 32'h55; RD2_E = 32'h77; MemWriteE = 1;
      run_cycle();
`ifdef EXECUTE_FORWARDING_EN
      check_val("fwd_a", ALU_ResultM, 32'h21);
      check_val("fwd_b", WriteDataM, 32'h55);
`else
      check_val("nofwd_a", ALU_ResultM, 32'h9A);
      check_val("nofwd_b", WriteDataM, 32'h77);
`endif

      // bubble with equal operands
      set_idle();
      RegWriteE = 1; MemWriteE = 1; BranchE = 1; ALUControlE = 3'b001; RD1_E = 3; RD2_E = 3;
      #1;
      check_val("bubble_pcsrc", {31'd0, PCSrcE}, 32'd0);
      run_cycle();
      check_val("bubble_valid", {31'd0, ValidM}, 32'd0);
      check_val("bubble_memwrite", {31'd0, MemWriteM}, 32'd0);

      // edge cases
      set_idle();
      ValidE = 1; ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
      run_cycle();
      check_val("slt_neg", ALU_ResultM, 32'd1);
      ALUControlE = 3'b000; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
      run_cycle();
      check_val("add_wrap", ALU_ResultM, 32'd0);
      ALUControlE = 3'b111; RD1_E = 32'h5; RD2_E = 32'h3;
      run_cycle();
      check_val("op_111", ALU_ResultM, 32'd0);

      // mid-stream reset
      ALUControlE = 3'b000; RD1_E = 32'h100; RD2_E = 32'h1; RegWriteE = 1; RD_E = 3;
      PCPlus4E = 32'h200;
      run_cycle();
      rst = 1;
      run_cycle();
      check_val("midrst_rd", {27'd0, RD_M}, 32'd0);
      check_val("midrst_regwrite", {31'd0, RegWriteM}, 32'd0);
      rst = 0;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(0, 31) == 0);
         RegWriteE   = $urandom_range(0, 1);
         ALUSrcE     = $urandom_range(0, 1);
         MemWriteE   = $urandom_range(0, 1);
         ResultSrcE  = $urandom_range(0, 1);
         BranchE     = $urandom_range(0, 1);
         ValidE      = ($urandom_range(0, 3) != 0);
         ALUControlE = 3'($urandom_range(0, 7));
         RD1_E       = $urandom();
         RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom();
         Imm_Ext_E   = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 15));
         PCE         = $urandom();
         PCPlus4E    = PCE + 4;
         RD_E        = 5'($urandom_range(0, 31));
         ForwardA_E  = 2'($urandom_range(0, 3));
         ForwardB_E  = 2'($urandom_range(0, 3));
         ResultW     = $urandom();
         run_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
